// File: rtl/usb4_tick_gen.sv
// usb4_tick_gen
// N-channel fractional clock-enable generator on local_clk. Each channel runs
// an ACC_W-bit phase accumulator; the carry out of acc+inc is registered as a
// one-cycle tick strobe (average rate = f_clk * inc / 2^ACC_W). Channel 0 is
// the sideband reference: a small sequencer holds rst_out low until RST_HOLD
// channel-0 ticks have been seen after rst deasserts.
//
// Optional feature macro: USB4_TICK_ALIGN_EN
//   defined     : align_req clears every accumulator and tick on that edge so
//                 integer-ratio channels restart coherent.
//   not defined : align_req is accepted but ignored.
module usb4_tick_gen #(
  parameter int NUM_CH   = 4,
  parameter int ACC_W    = 32,
  parameter int RST_HOLD = 3
) (
  input  logic                    local_clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic                    align_req,
  output logic [NUM_CH-1:0]       tick,
  output logic                    rst_out,
  output logic                    seq_busy
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

  localparam logic [7:0] HOLD = 8'(RST_HOLD);

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];
  logic             align_hit;
  seq_state_t       seq_state;
  logic [7:0]       hold_cnt;

`ifdef USB4_TICK_ALIGN_EN
  assign align_hit = align_req;
`else
  // Port kept for a stable interface; alignment is compiled out.
  logic unused_align;
  assign unused_align = align_req;
  assign align_hit    = 1'b0;
`endif

  // Per-channel sum with carry; the carry bit becomes the tick strobe.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // Accumulators, active increments and registered tick strobes. The sum
  // always uses the increment held before this edge, so a cfg_load only
  // affects accumulation from the following edge on.
  always_ff @(posedge local_clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
      end
      tick <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (align_hit || !ch_en[i]) begin
          acc[i]  <= '0;
          tick[i] <= 1'b0;
        end else begin
          acc[i]  <= sum[i][ACC_W-1:0];
          tick[i] <= sum[i][ACC_W];
        end
        if (cfg_load[i]) begin
          inc[i] <= cfg_inc[i*ACC_W +: ACC_W];
        end
      end
    end
  end

  // Reset sequencer: counts registered channel-0 ticks after rst releases and
  // raises rst_out on the edge that observes the RST_HOLD-th one.
  always_ff @(posedge local_clk) begin
    if (!rst) begin
      seq_state <= ST_RESET;
      hold_cnt  <= '0;
      rst_out   <= 1'b0;
      seq_busy  <= 1'b0;
    end else begin
      case (seq_state)
        ST_RESET: begin
          seq_state <= ST_COUNT;
          hold_cnt  <= '0;
          rst_out   <= 1'b0;
          seq_busy  <= 1'b1;
        end
        ST_COUNT: begin
          if (tick[0]) begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt + 8'd1 == HOLD) begin
              seq_state <= ST_RUN;
              rst_out   <= 1'b1;
              seq_busy  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          rst_out  <= 1'b1;
          seq_busy <= 1'b0;
        end
        default: begin
          seq_state <= ST_RESET;
          hold_cnt  <= '0;
          rst_out   <= 1'b0;
          seq_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
